wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 190 +++++++++++++++++++
 tb/tb_wb_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : Register-file write-back arbiter. Single-cycle ALU results
//               write immediately; multi-cycle (mul/div) results wait in a
//               small FIFO and drain on cycles the ALU leaves idle. An ALU
//               write supersedes queued results for the same register, and
//               a hazard flag covers every pending write.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     aluValid,
  input  logic [4:0]               aluAddr,
  input  logic [WIDTH-1:0]         aluData,
  input  logic                     mdValid,
  input  logic [4:0]               mdAddr,
  input  logic [WIDTH-1:0]         mdData,
  output logic                     mdReady,
  input  logic [4:0]               readAddr1,
  input  logic [4:0]               readAddr2,
  output logic                     hazard,
  output logic                     writeEn,
  output logic [4:0]               writeAddr,
  output logic [WIDTH-1:0]         writeData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage. Valid entries are always contiguous from the read pointer,
  // so occupancy and the number of valid entries are the same thing.
  logic [4:0]       r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic [4:0]       w_addr_nxt [DEPTH];
  logic [WIDTH-1:0] w_data_nxt [DEPTH];
  logic [DEPTH-1:0] w_valid_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_kept;
  logic [PW-1:0]    w_src;
  logic [PW-1:0]    w_dst;

  logic             w_alu_wr;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_kill;
  logic             w_any_kill;
  logic [DEPTH-1:0] w_hit;
  logic             w_out_hit;

  assign mdReady  = (r_count < CW'(DEPTH));
  assign count    = r_count;

  // Register 0 is hard-wired; results aimed at it are dropped (md side is
  // still handshaken so the producer is not blocked).
  assign w_alu_wr = aluValid && (aluAddr != 5'd0);
  assign w_push   = mdValid && mdReady && (mdAddr != 5'd0);
  // The queue only drains when the ALU leaves the write port idle; an entry
  // pushed this cycle is not yet counted, so it cannot pop this cycle.
  assign w_pop    = !aluValid && (r_count != '0);

  // Per-entry comparators: superseded-by-ALU kill and read-port hazard.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_cmp
      assign w_kill[i] = w_alu_wr && r_valid[i] && (r_addr[i] == aluAddr);
      assign w_hit[i]  = r_valid[i] && (r_addr[i] != 5'd0) &&
                         ((r_addr[i] == readAddr1) || (r_addr[i] == readAddr2));
    end
  endgenerate

  assign w_any_kill = |w_kill;
  assign w_out_hit  = writeEn && (writeAddr != 5'd0) &&
                      ((writeAddr == readAddr1) || (writeAddr == readAddr2));
  assign hazard     = (|w_hit) || w_out_hit;

  // Next queue state. The common case is a plain FIFO update; a kill instead
  // rebuilds the queue from the read pointer, squeezing out killed entries so
  // occupancy stays equal to the valid count and order is preserved.
  always_comb begin
    w_valid_nxt  = r_valid;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    w_kept       = '0;
    w_src        = '0;
    w_dst        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_addr_nxt[i] = r_addr[i];
      w_data_nxt[i] = r_data[i];
    end

    if (w_any_kill) begin
      // A kill implies an active ALU, so there is no pop on this path.
      w_valid_nxt = '0;
      for (int j = 0; j < DEPTH; j++) begin
        w_src = r_rd_ptr + PW'(j);
        if (r_valid[w_src] && !w_kill[w_src]) begin
          w_dst              = r_rd_ptr + w_kept[PW-1:0];
          w_valid_nxt[w_dst] = 1'b1;
          w_addr_nxt[w_dst]  = r_addr[w_src];
          w_data_nxt[w_dst]  = r_data[w_src];
          w_kept             = w_kept + CW'(1);
        end
      end
      // The md result arriving this cycle is appended after the survivors
      // and is never subject to the kill.
      if (w_push) begin
        w_dst              = r_rd_ptr + w_kept[PW-1:0];
        w_valid_nxt[w_dst] = 1'b1;
        w_addr_nxt[w_dst]  = mdAddr;
        w_data_nxt[w_dst]  = mdData;
      end
      w_count_nxt  = w_kept + (w_push ? CW'(1) : CW'(0));
      w_wr_ptr_nxt = r_rd_ptr + w_count_nxt[PW-1:0];
    end else begin
      if (w_pop) begin
        w_valid_nxt[r_rd_ptr] = 1'b0;
        w_rd_ptr_nxt          = r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        w_valid_nxt[r_wr_ptr] = 1'b1;
        w_addr_nxt[r_wr_ptr]  = mdAddr;
        w_data_nxt[r_wr_ptr]  = mdData;
        w_wr_ptr_nxt          = r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Queue state registers; reset discards every pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_valid  <= w_valid_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= w_addr_nxt[i];
        r_data[i] <= w_data_nxt[i];
      end
    end
  end

  // Registered write port: ALU first, else queue head; address/data hold
  // their last values whenever no write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else if (w_alu_wr) begin
      writeEn   <= 1'b1;
      writeAddr <= aluAddr;
      writeData <= aluData;
    end else if (w_pop) begin
      writeEn   <= 1'b1;
      writeAddr <= r_addr[r_rd_ptr];
      writeData <= r_data[r_rd_ptr];
    end else begin
      writeEn   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_queue
// Description : Directed self-checking bench for wb_queue (DEPTH=4, WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

  logic        clk;
  logic        reset;
  logic        aluValid;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        mdValid;
  logic [4:0]  mdAddr;
  logic [31:0] mdData;
  logic        mdReady;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic        hazard;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData),
    .mdValid(mdValid), .mdAddr(mdAddr), .mdData(mdData), .mdReady(mdReady),
    .readAddr1(readAddr1), .readAddr2(readAddr2), .hazard(hazard),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                        input logic [31:0] d, input logic [2:0] c);
    chk({tag, ".writeEn"},   32'(writeEn),   32'(en));
    chk({tag, ".writeAddr"}, 32'(writeAddr), 32'(a));
    chk({tag, ".writeData"}, writeData,      d);
    chk({tag, ".count"},     32'(count),     32'(c));
  endtask

  initial begin
    reset = 1'b1; aluValid = 0; aluAddr = 0; aluData = 0;
    mdValid = 0; mdAddr = 0; mdData = 0; readAddr1 = 0; readAddr2 = 0;
    #2;
    chk_wr("reset", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("reset.mdReady", 32'(mdReady), 32'd1);
    chk("reset.hazard",  32'(hazard),  32'd0);
    step();
    reset = 1'b0;
    step();

    // ALU only
    aluValid = 1; aluAddr = 5'd5; aluData = 32'h1234;
    step();
    aluValid = 0;
    chk_wr("alu", 1'b1, 5'd5, 32'h1234, 3'd0);
    step();
    chk_wr("alu_idle_hold", 1'b0, 5'd5, 32'h1234, 3'd0);

    // Fill under continuous ALU traffic, then backpressure
    aluValid = 1; aluAddr = 5'd9; aluData = 32'h99;
    mdValid = 1;
    for (int i = 1; i <= 4; i++) begin
      mdAddr = 5'(i); mdData = 32'h100 + 32'(i);
      step();
      chk_wr($sformatf("fill%0d", i), 1'b1, 5'd9, 32'h99, 3'(i));
    end
    chk("full.mdReady", 32'(mdReady), 32'd0);
    mdAddr = 5'd5; mdData = 32'h105;
    step();
    chk_wr("fifth_waits", 1'b1, 5'd9, 32'h99, 3'd4);
    chk("fifth_waits.mdReady", 32'(mdReady), 32'd0);
    aluValid = 0;
    // Full queue draining: mdReady stays low on this edge, so no push.
    step();
    chk_wr("drain1", 1'b1, 5'd1, 32'h101, 3'd3);
    chk("drain1.mdReady", 32'(mdReady), 32'd1);
    // Simultaneous push of 5 and pop of 2.
    step();
    mdValid = 0;
    chk_wr("drain2", 1'b1, 5'd2, 32'h102, 3'd3);
    step();
    chk_wr("drain3", 1'b1, 5'd3, 32'h103, 3'd2);
    step();
    chk_wr("drain4", 1'b1, 5'd4, 32'h104, 3'd1);
    step();
    chk_wr("drain5", 1'b1, 5'd5, 32'h105, 3'd0);
    step();
    chk_wr("drain_idle", 1'b0, 5'd5, 32'h105, 3'd0);

    // Kill: ALU write supersedes queued result to same register
    mdValid = 1; mdAddr = 5'd7; mdData = 32'hAA;
    step();
    mdValid = 0;
    chk_wr("kill_push", 1'b0, 5'd5, 32'h105, 3'd1);
    aluValid = 1; aluAddr = 5'd7; aluData = 32'hBB;
    step();
    aluValid = 0;
    chk_wr("kill_alu", 1'b1, 5'd7, 32'hBB, 3'd0);
    step();
    chk_wr("kill_no_second", 1'b0, 5'd7, 32'hBB, 3'd0);

    // $zero suppression on both paths
    aluValid = 1; aluAddr = 5'd0; aluData = 32'h55;
    mdValid = 1; mdAddr = 5'd0; mdData = 32'h66;
    step();
    aluValid = 0; mdValid = 0;
    chk_wr("zero", 1'b0, 5'd7, 32'hBB, 3'd0);
    step();
    chk_wr("zero_after", 1'b0, 5'd7, 32'hBB, 3'd0);

    // Hazard: queued addr 3 held back by ALU traffic
    aluValid = 1; aluAddr = 5'd10; aluData = 32'hA0;
    mdValid = 1; mdAddr = 5'd3; mdData = 32'h33;
    step();
    mdValid = 0;
    readAddr2 = 5'd3; #1;
    chk("hazard_queue", 32'(hazard), 32'd1);
    chk("hazard_queue.count", 32'(count), 32'd1);
    readAddr2 = 5'd0; #1;
    chk("hazard_none", 32'(hazard), 32'd0);
    readAddr1 = 5'd10; #1;
    chk("hazard_output", 32'(hazard), 32'd1);
    readAddr1 = 5'd0;

    // Reset mid-drain
    mdValid = 1; mdAddr = 5'd11; mdData = 32'h111;
    step();
    mdAddr = 5'd12; mdData = 32'h112;
    step();
    chk("pre_drain.count", 32'(count), 32'd3);
    mdValid = 0; aluValid = 0;
    step();
    chk_wr("mid_drain", 1'b1, 5'd3, 32'h33, 3'd2);
    readAddr2 = 5'd11; #1;
    chk("mid_drain.hazard", 32'(hazard), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_wr("async_reset", 1'b0, 5'd0, 32'h0, 3'd0);
    chk("async_reset.mdReady", 32'(mdReady), 32'd1);
    chk("async_reset.hazard",  32'(hazard),  32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_wr($sformatf("post_reset%0d", i), 1'b0, 5'd0, 32'h0, 3'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
